// File: rtl/cntdown_timer.sv
// rtl/cntdown_timer.sv - loadable down-counter/timer with terminal-count pulse
//
// Counts a loaded value down to zero, then pulses tc for one cycle.
// Optional periodic mode is compiled in by defining CNTDOWN_AUTORELOAD_EN.
// Without it the timer is one-shot only and auto_reload is ignored.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-low reset
//   en          count enable; decrement allowed when high while running
//   load        load strobe; captures load_val, highest priority after reset
//   load_val    start/reload value (N bits)
//   auto_reload periodic mode select, sampled every cycle
//   cnt         current count (registered)
//   tc          terminal-count pulse (registered, high only in DONE)
//   busy        high while running (registered)

module cntdown_timer #(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         auto_reload,
  output logic [N-1:0] cnt,
  output logic         tc,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // periodic: high when the timer should restart itself after terminal count.
  // reload_val: value restored into cnt on the RUN->DONE transition.
  logic         periodic;
  logic [N-1:0] reload_val;

`ifdef CNTDOWN_AUTORELOAD_EN
  logic [N-1:0] reload_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      reload_q <= '0;
    end else if (load) begin
      reload_q <= load_val;
    end
  end

  assign periodic   = auto_reload;
  assign reload_val = reload_q;
`else
  // One-shot build: the mode input is deliberately left without effect.
  logic unused_auto_reload;
  assign unused_auto_reload = auto_reload;
  assign periodic           = 1'b0;
  assign reload_val         = '0;
`endif

  // tc and busy are written alongside state so each always equals the
  // decode of the state being entered; nothing combinational reaches a port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      tc    <= 1'b0;
      busy  <= 1'b0;
    end else if (load) begin
      cnt <= load_val;
      tc  <= 1'b0;
      if (load_val != '0) begin
        state <= RUN;
        busy  <= 1'b1;
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          tc   <= 1'b0;
          busy <= 1'b0;
        end
        RUN: begin
          if (en) begin
            // cnt is never 0 in RUN (a zero load goes to IDLE), so the
            // terminal test also covers that case and no wrap can occur.
            if (cnt <= N'(1)) begin
              state <= DONE;
              cnt   <= periodic ? reload_val : '0;
              tc    <= 1'b1;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - N'(1);
            end
          end
        end
        DONE: begin
          // One cycle only; cnt holds whether or not en is high.
          tc <= 1'b0;
          if (periodic) begin
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          tc    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cntdown_timer.sv
// tb/tb_cntdown_timer.sv - directed self-checking bench for cntdown_timer

module tb_cntdown_timer;

  localparam int N = 7;

  logic         clk;
  logic         rst;
  logic         en;
  logic         load;
  logic [N-1:0] load_val;
  logic         auto_reload;
  logic [N-1:0] cnt;
  logic         tc;
  logic         busy;

  int checks;
  int fails;

  cntdown_timer #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load        (load),
    .load_val    (load_val),
    .auto_reload (auto_reload),
    .cnt         (cnt),
    .tc          (tc),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; load = 1'b0; en = 1'b0; auto_reload = 1'b0; load_val = '0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b1; load_val = 7'd9; en = 1'b1; auto_reload = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({cnt, tc, busy} !== {7'd0, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL reset[%0d]: cnt=%0d tc=%b busy=%b, expected cnt=0 tc=0 busy=0", i, cnt, tc, busy);
      end
    end
    load = 1'b0; en = 1'b0; rst = 1'b1;
  endtask

  task automatic test_one_shot();
    int exp_cnt [7] = '{5, 4, 3, 2, 1, 0, 0};
    bit exp_tc  [7] = '{0, 0, 0, 0, 0, 1, 0};
    bit exp_bsy [7] = '{1, 1, 1, 1, 1, 0, 0};
    load = 1'b1; load_val = 7'd5; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      load = 1'b0;
      checks++;
      if ({cnt, tc, busy} !== {N'(exp_cnt[i]), exp_tc[i], exp_bsy[i]}) begin
        fails++;
        $display("FAIL one_shot[k+%0d]: cnt=%0d tc=%b busy=%b, expected cnt=%0d tc=%b busy=%b",
                 i, cnt, tc, busy, exp_cnt[i], exp_tc[i], exp_bsy[i]);
      end
    end
  endtask

  task automatic test_enable_gating();
    bit en_pat  [5] = '{1, 0, 0, 1, 1};
    int exp_cnt [5] = '{2, 2, 2, 1, 0};
    bit exp_tc  [5] = '{0, 0, 0, 0, 1};
    load = 1'b1; load_val = 7'd3; en = 1'b0;
    step();
    load = 1'b0;
    checks++;
    if ({cnt, tc, busy} !== {7'd3, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL gating_load: cnt=%0d tc=%b busy=%b, expected cnt=3 tc=0 busy=1", cnt, tc, busy);
    end
    for (int i = 0; i < 5; i++) begin
      en = en_pat[i];
      step();
      checks++;
      if ({cnt, tc} !== {N'(exp_cnt[i]), exp_tc[i]}) begin
        fails++;
        $display("FAIL gating[%0d]: cnt=%0d tc=%b, expected cnt=%0d tc=%b",
                 i, cnt, tc, exp_cnt[i], exp_tc[i]);
      end
    end
    en = 1'b0;
    step();
  endtask

  task automatic test_load_zero();
    load = 1'b1; load_val = 7'd0; en = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({cnt, tc, busy} !== {7'd0, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL load_zero[%0d]: cnt=%0d tc=%b busy=%b, expected cnt=0 tc=0 busy=0", i, cnt, tc, busy);
      end
      step();
    end
    en = 1'b0;
  endtask

  task automatic test_load_max();
    int exp_c;
    load = 1'b1; load_val = 7'd127; en = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if ({cnt, busy} !== {7'd127, 1'b1}) begin
      fails++;
      $display("FAIL max_load: cnt=%0d busy=%b, expected cnt=127 busy=1", cnt, busy);
    end
    for (int i = 1; i <= 127; i++) begin
      step();
      exp_c = (i == 127) ? 0 : 127 - i;
      checks++;
      if ({cnt, tc} !== {N'(exp_c), (i == 127)}) begin
        fails++;
        $display("FAIL max_count[%0d]: cnt=%0d tc=%b, expected cnt=%0d tc=%b", i, cnt, tc, exp_c, (i == 127));
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({cnt, tc, busy} !== {7'd0, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL no_underflow[%0d]: cnt=%0d tc=%b busy=%b, expected cnt=0 tc=0 busy=0", i, cnt, tc, busy);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_priority();
    load = 1'b1; load_val = 7'd5; en = 1'b1;
    step();
    load = 1'b0;
    step(); step(); step();
    checks++;
    if (cnt !== 7'd2) begin
      fails++;
      $display("FAIL prio_setup: cnt=%0d, expected 2", cnt);
    end
    load = 1'b1; load_val = 7'd7;
    step();
    load = 1'b0; en = 1'b0;
    checks++;
    if ({cnt, tc, busy} !== {7'd7, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL prio_reload: cnt=%0d tc=%b busy=%b, expected cnt=7 tc=0 busy=1", cnt, tc, busy);
    end
    step(); step();
    checks++;
    if ({cnt, tc, busy} !== {7'd7, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL prio_hold: cnt=%0d tc=%b busy=%b, expected cnt=7 tc=0 busy=1", cnt, tc, busy);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_run();
    load = 1'b1; load_val = 7'd6; en = 1'b1;
    step();
    load = 1'b0;
    step(); step();
    checks++;
    if (cnt !== 7'd4) begin
      fails++;
      $display("FAIL midrun_setup: cnt=%0d, expected 4", cnt);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++;
    if ({cnt, tc, busy} !== {7'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL midrun_reset: cnt=%0d tc=%b busy=%b, expected cnt=0 tc=0 busy=0", cnt, tc, busy);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({cnt, tc, busy} !== {7'd0, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL midrun_after[%0d]: cnt=%0d tc=%b busy=%b, expected cnt=0 tc=0 busy=0", i, cnt, tc, busy);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_auto_reload();
`ifdef CNTDOWN_AUTORELOAD_EN
    int exp_cnt [10] = '{3, 2, 1, 4, 4, 3, 2, 1, 4, 4};
    bit exp_tc  [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    bit exp_bsy [10] = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
`else
    int exp_cnt [10] = '{3, 2, 1, 0, 0, 0, 0, 0, 0, 0};
    bit exp_tc  [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    bit exp_bsy [10] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
`endif
    load = 1'b1; load_val = 7'd4; en = 1'b1; auto_reload = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if ({cnt, tc, busy} !== {7'd4, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL auto_load: cnt=%0d tc=%b busy=%b, expected cnt=4 tc=0 busy=1", cnt, tc, busy);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({cnt, tc, busy} !== {N'(exp_cnt[i]), exp_tc[i], exp_bsy[i]}) begin
        fails++;
        $display("FAIL auto[%0d]: cnt=%0d tc=%b busy=%b, expected cnt=%0d tc=%b busy=%b",
                 i, cnt, tc, busy, exp_cnt[i], exp_tc[i], exp_bsy[i]);
      end
    end
    do_reset();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; auto_reload = 1'b0;
    test_reset();
    test_one_shot();
    test_enable_gating();
    test_load_zero();
    test_load_max();
    test_load_priority();
    test_reset_mid_run();
    test_auto_reload();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cntdown_timer.md
# cntdown_timer

Loadable down-counter/timer: the decrementing counterpart of the team's free-running up counter. It counts a programmed value down to zero and signals terminal count with a one-cycle pulse. Cycle-accurate RTL suitable for the same formal equivalence flow as the counter blocks. Used as a timeout/interval generator next to the up counter.

## Interface
- N, 7, counter width in bits; legal load values 0..2^N-1.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.
- en  input  1  count enable; decrement allowed when high.
- load  input  1  load strobe; captures load_val.
- load_val  input  N  start/reload value.
- auto_reload  input  1  periodic mode select; sampled every cycle. Ignored unless CNTDOWN_AUTORELOAD_EN is defined.
- cnt  output  N  current count, registered.
- tc  output  1  terminal-count pulse, registered; high only in DONE.
- busy  output  1  high while in RUN.

## Operation
- Reset: when rst==0 at a rising edge:
  - state=IDLE, cnt=0, reload register=0, tc=0, busy=0.
  - Reset overrides load and en.
- FSM states: IDLE, RUN, DONE. tc=(state==DONE); busy=(state==RUN).
- load (any state, rst high):
  - reload register <= load_val; cnt <= load_val.
  - Next state is RUN if load_val!=0, else IDLE with no tc.
  - load has priority over en and over every other transition.
- IDLE: cnt holds; en ignored.
- RUN, en=0: cnt holds; state stays RUN.
- RUN, en=1, cnt>1: cnt <= cnt-1.
- RUN, en=1, cnt==1 -> DONE:
  - One-shot mode: cnt <= 0.
  - Auto-reload mode: cnt <= reload register.
- DONE lasts exactly one cycle and never decrements, regardless of en.
  - One-shot: DONE -> IDLE, cnt stays 0.
  - Auto-reload: DONE -> RUN, cnt stays at the reload value.
- No underflow or wrap-around: cnt never transitions 0 -> 2^N-1.
- Arithmetic: N-bit unsigned subtraction only; no carry out.

## Timing
- Load at edge k: cnt=load_val and busy=1 visible after edge k.
- With en held high, tc is high in the cycle after edge k+load_val.
- Auto-reload period: load_val+1 cycles per tc pulse.
- Every output is a register; no combinational path from any input to any output.
- Reset mid-RUN or mid-DONE: outputs reach reset values after that edge; any in-flight tc is dropped.

## Configuration
- CNTDOWN_AUTORELOAD_EN defined:
  - auto_reload is honoured.
  - Reload register feeds cnt on the RUN->DONE transition.
- Not defined:
  - auto_reload port is present but ignored; behaviour is pure one-shot.
  - The reload register may be optimised away.
  - Default build is one-shot only.

## Test plan
- Reset: hold rst=0 for 2 cycles with load=1, load_val=9 -> cnt=0, tc=0, busy=0, state IDLE.
- One-shot: load 5 at edge k, en=1 -> cnt 5,4,3,2,1,0 after edges k..k+5; tc=1 only after edge k+5; IDLE and tc=0 after k+6.
- Enable gating: load 3, en pattern 1,0,0,1,1 -> cnt 3,2,2,2,1,0 then tc; no tc during pauses.
- Boundaries:
  - load 0 -> IDLE, cnt=0, no tc.
  - load 127 with en=1 -> tc after exactly 127 enabled edges.
  - No underflow occurs.
- Priority and reset:
  - load 7 issued while cnt=2 in RUN -> cnt=7, no tc.
  - rst=0 asserted while cnt=4 in RUN -> cnt=0, busy=0, tc never asserted.
- Auto-reload (CNTDOWN_AUTORELOAD_EN defined): load 4, auto_reload=1, en=1 -> cnt 4,3,2,1,4(tc),4,3,2,1,4(tc); period 5. Without the macro, same stimulus -> single tc, then IDLE.
